qam_frame_sched: RTL

//  Frame scheduler for the QAM16 transmit chain (PRBS source -> symmap -> upsampler).

---
 rtl/qam_frame_sched_if.sv | 20 ++
 rtl/qam_frame_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/qam_frame_sched_if.sv
// Payload source handshake between the PRBS source and the frame scheduler.
// The master (source) drives src_data/src_valid; the slave (scheduler)
// drives src_ready, a registered-decode strobe that marks the consume cycle.
interface qam_frame_sched_if;
    logic [3:0] src_data;
    logic       src_valid;
    logic       src_ready;

    modport master (
        output src_data,
        output src_valid,
        input  src_ready
    );

    modport slave (
        input  src_data,
        input  src_valid,
        output src_ready
    );
endinterface

// File: rtl/qam_frame_sched.sv
// qam_frame_sched: QAM16 transmit frame scheduler.
// Each frame is PREAMBLE -> PAYLOAD -> GAP at symbol rate. Each symbol lasts
// UPS samples, and phase counts the samples within a symbol. Payload nibbles
// are pulled from the source. A missing nibble becomes a zero symbol and
// sets the sticky underflow flag. The frame length never changes.
// Optional feature: define QAM_FRAME_CNT_EN to add a 16-bit frame_cnt output.
// frame_cnt counts done pulses and wraps.
module qam_frame_sched #(
    parameter int unsigned UPS     = 32'd4,
    parameter int unsigned PRE_LEN = 32'd8,
    parameter int unsigned PAY_LEN = 32'd32,
    parameter int unsigned GAP_LEN = 32'd4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    qam_frame_sched_if.slave       src,
    output logic [3:0]             sym_data,
    output logic                   sym_zero,
    output logic                   sym_stb,
    output logic [3:0]             phase,
    output logic                   busy,
    output logic                   done,
    output logic                   underflow
`ifdef QAM_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_PAY  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0]  PH_LAST  = 4'(UPS - 32'd1);
    localparam logic [3:0]  PH_PEN   = 4'(UPS - 32'd2);
    localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 32'd1);
    localparam logic [15:0] PAY_LAST = 16'(PAY_LEN - 32'd1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 32'd1);

    // Preamble pattern: even symbols 4'h0, odd symbols 4'hF.
    function automatic logic [3:0] pre_sym(input logic odd);
        return odd ? 4'hF : 4'h0;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [15:0] sym_cnt_q, sym_cnt_d;
    logic [3:0]  sym_data_q, sym_data_d;
    logic        sym_zero_q, sym_zero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        underflow_q, underflow_d;
    logic        pending_q, pending_d;

    logic        sym_last_s;
    logic [3:0]  pay_data_s;
    logic        pay_zero_s;

    // Register decodes: symbol boundary, payload fetch strobe, payload value.
    always_comb begin
        sym_last_s    = (phase_q == PH_LAST);
        src.src_ready = sym_last_s &&
                        (((state_q == ST_PRE) && (sym_cnt_q == PRE_LAST)) ||
                         ((state_q == ST_PAY) && (sym_cnt_q != PAY_LAST)));
        pay_data_s    = src.src_valid ? src.src_data : 4'h0;
        pay_zero_s    = ~src.src_valid;
    end

    // Next-state logic: frame sequencing, symbol loading, pending start.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sym_cnt_d   = sym_cnt_q;
        sym_data_d  = sym_data_q;
        sym_zero_d  = sym_zero_q;
        busy_d      = busy_q;
        underflow_d = underflow_q;
        // A start while busy is remembered once; the frame end consumes it.
        pending_d   = pending_q | (start & busy_q);
        // done is registered, so it is set one sample before the last GAP sample.
        done_d      = (state_q == ST_GAP) && (sym_cnt_q == GAP_LAST) &&
                      (phase_q == PH_PEN);

        case (state_q)
            ST_IDLE: begin
                phase_d    = 4'd0;
                sym_cnt_d  = 16'd0;
                sym_data_d = 4'h0;
                pending_d  = 1'b0;
                if (start) begin
                    state_d     = ST_PRE;
                    busy_d      = 1'b1;
                    sym_zero_d  = 1'b0;
                    underflow_d = 1'b0;
                end else begin
                    busy_d      = 1'b0;
                    sym_zero_d  = 1'b1;
                end
            end
            ST_PRE: begin
                if (sym_last_s) begin
                    phase_d = 4'd0;
                    if (sym_cnt_q == PRE_LAST) begin
                        state_d     = ST_PAY;
                        sym_cnt_d   = 16'd0;
                        sym_data_d  = pay_data_s;
                        sym_zero_d  = pay_zero_s;
                        underflow_d = underflow_q | pay_zero_s;
                    end else begin
                        sym_cnt_d  = sym_cnt_q + 16'd1;
                        // Next index is odd exactly when the current one is even.
                        sym_data_d = pre_sym(~sym_cnt_q[0]);
                        sym_zero_d = 1'b0;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_PAY: begin
                if (sym_last_s) begin
                    phase_d = 4'd0;
                    if (sym_cnt_q == PAY_LAST) begin
                        state_d    = ST_GAP;
                        sym_cnt_d  = 16'd0;
                        sym_data_d = 4'h0;
                        sym_zero_d = 1'b1;
                    end else begin
                        sym_cnt_d   = sym_cnt_q + 16'd1;
                        sym_data_d  = pay_data_s;
                        sym_zero_d  = pay_zero_s;
                        underflow_d = underflow_q | pay_zero_s;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (sym_last_s) begin
                    phase_d    = 4'd0;
                    sym_data_d = 4'h0;
                    if (sym_cnt_q == GAP_LAST) begin
                        sym_cnt_d = 16'd0;
                        pending_d = 1'b0;
                        // A start on the done cycle counts as pending.
                        if (pending_q || start) begin
                            state_d     = ST_PRE;
                            sym_zero_d  = 1'b0;
                            underflow_d = 1'b0;
                        end else begin
                            state_d    = ST_IDLE;
                            busy_d     = 1'b0;
                            sym_zero_d = 1'b1;
                        end
                    end else begin
                        sym_cnt_d  = sym_cnt_q + 16'd1;
                        sym_zero_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                phase_d    = 4'd0;
                sym_cnt_d  = 16'd0;
                sym_data_d = 4'h0;
                sym_zero_d = 1'b1;
                busy_d     = 1'b0;
                pending_d  = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns to IDLE with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 4'd0;
            sym_cnt_q   <= 16'd0;
            sym_data_q  <= 4'h0;
            sym_zero_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sym_cnt_q   <= sym_cnt_d;
            sym_data_q  <= sym_data_d;
            sym_zero_q  <= sym_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            pending_q   <= pending_d;
        end
    end

    assign sym_data  = sym_data_q;
    assign sym_zero  = sym_zero_q;
    assign sym_stb   = busy_q && (phase_q == 4'd0);
    assign phase     = phase_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underflow = underflow_q;

`ifdef QAM_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter: one count per done pulse, natural 16-bit wrap.
    always_comb begin
        if (done_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
